// File: rtl/display_scanner_if.sv
// Bundle between the microwave digit decoder/controller and the display scanner.
// Latency: none, plain wires. Backpressure: none, free-running display path.
// Ports: mag_on + four decoded digit buses in; shared seg bus, anodes, dp out.
interface display_scanner_if;
    logic       mag_on;
    logic [6:0] sec_ones_segs;
    logic [6:0] sec_tens_segs;
    logic [6:0] min_ones_segs;
    logic [6:0] min_tens_segs;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;

    // master: controller/decoder side (drives digits, watches display pins)
    modport master (
        output mag_on, sec_ones_segs, sec_tens_segs, min_ones_segs, min_tens_segs,
        input  seg, an, dp
    );

    // slave: the scanner itself
    modport slave (
        input  mag_on, sec_ones_segs, sec_tens_segs, min_ones_segs, min_tens_segs,
        output seg, an, dp
    );
endinterface

// File: rtl/display_scanner.sv
// Time-multiplexes four 7-segment digits onto one bus with active-low anodes,
// leading-zero blanking on minutes, a one-cycle ghost gap and a blinking colon.
// Latency: seg/dp load 1 cycle after a slot tick, anode lights 2 cycles after.
// Backpressure: none; inputs are snapshotted once per frame, never stalled.
// Ports: clk, rst (sync, active-high); bus (slave) carries mag_on, the four
//        digit buses in, and registered seg[6:0], an[3:0] (bit0=sec_ones), dp out.
module display_scanner #(
    parameter int         REFRESH_DIV = 50000,
    parameter int         BLINK_HALF  = 25000000,
    parameter logic [6:0] SEG_ZERO    = 7'b0111111,
    parameter logic [6:0] SEG_BLANK   = 7'b0000000
) (
    input  logic               clk,
    input  logic               rst,
    display_scanner_if.slave   bus
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 2;
    localparam int BLK_W = (BLINK_HALF > 2) ? $clog2(BLINK_HALF) : 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // after reset, before the first slot tick
        ST_GAP  = 2'd1,   // anodes dark, seg already holds the new digit
        ST_LIT  = 2'd2    // anode for idx driven until the next tick
    } state_t;

    // ---------------- prescaler / slot index ----------------
    logic [CNT_W-1:0] pre_cnt;
    logic             tick;
    logic [1:0]       idx;
    logic [1:0]       idx_nxt;
    logic             wrap;

    assign tick    = (pre_cnt == CNT_W'(REFRESH_DIV - 1));
    assign idx_nxt = idx + 2'd1;
    assign wrap    = tick && (idx == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt <= '0;
            idx     <= 2'd3;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + CNT_W'(1);
            if (tick) begin
                idx <= idx_nxt;
            end
        end
    end

    // ---------------- frame snapshot ----------------
    logic [6:0] snap_so, snap_st, snap_mo, snap_mt;

    always_ff @(posedge clk) begin
        if (rst) begin
            snap_so <= SEG_BLANK;
            snap_st <= SEG_BLANK;
            snap_mo <= SEG_BLANK;
            snap_mt <= SEG_BLANK;
        end else if (wrap) begin
            snap_so <= bus.sec_ones_segs;
            snap_st <= bus.sec_tens_segs;
            snap_mo <= bus.min_ones_segs;
            snap_mt <= bus.min_tens_segs;
        end
    end

    // Slot 0 of a new frame is loaded on the same edge the snapshot is taken,
    // so at a wrap the live inputs stand in for the not-yet-updated snapshot.
    logic [6:0] eff_so, eff_st, eff_mo, eff_mt;
    assign eff_so = wrap ? bus.sec_ones_segs : snap_so;
    assign eff_st = wrap ? bus.sec_tens_segs : snap_st;
    assign eff_mo = wrap ? bus.min_ones_segs : snap_mo;
    assign eff_mt = wrap ? bus.min_tens_segs : snap_mt;

    logic mt_zero, mo_zero;
    assign mt_zero = (eff_mt == SEG_ZERO);
    assign mo_zero = (eff_mo == SEG_ZERO);

    logic [6:0] slot_seg;
    always_comb begin
        slot_seg = SEG_BLANK;
        case (idx_nxt)
            2'd0: slot_seg = eff_so;
            2'd1: slot_seg = eff_st;
            2'd2: slot_seg = (mt_zero && mo_zero) ? SEG_BLANK : eff_mo;
            2'd3: slot_seg = mt_zero ? SEG_BLANK : eff_mt;
            default: slot_seg = SEG_BLANK;
        endcase
    end

    // ---------------- colon blink ----------------
    logic [BLK_W-1:0] blink_cnt;
    logic             blink_on;
    logic             colon_on;

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (!bus.mag_on) begin
            // held so the colon starts a fresh full "on" half-period at mag_on rise
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (blink_cnt == BLK_W'(BLINK_HALF - 1)) begin
            blink_cnt <= '0;
            blink_on  <= ~blink_on;
        end else begin
            blink_cnt <= blink_cnt + BLK_W'(1);
        end
    end

    assign colon_on = !bus.mag_on || blink_on;

    // ---------------- slot output FSM ----------------
    state_t     state, state_nxt;
    logic [6:0] seg_d;
    logic [3:0] an_d;
    logic       dp_d;
    logic [3:0] an_sel;

    assign an_sel = 4'b0001 << idx;

    // state register, also registering the outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            bus.seg <= SEG_BLANK;
            bus.an  <= 4'b1111;
            bus.dp  <= 1'b1;
        end else begin
            state  <= state_nxt;
            bus.seg <= seg_d;
            bus.an  <= an_d;
            bus.dp  <= dp_d;
        end
    end

    // next-state logic; REFRESH_DIV >= 4 keeps a tick from landing in ST_GAP
    always_comb begin
        state_nxt = state;
        if (tick) begin
            state_nxt = ST_GAP;
        end else if (state == ST_GAP) begin
            state_nxt = ST_LIT;
        end
    end

    // output next-values: blank anodes and load digit on tick, light one cycle later
    always_comb begin
        seg_d = bus.seg;
        an_d  = bus.an;
        dp_d  = bus.dp;
        if (tick) begin
            an_d  = 4'b1111;
            seg_d = slot_seg;
            dp_d  = !((idx_nxt == 2'd2) && colon_on);
        end else if (state == ST_GAP) begin
            an_d = ~an_sel;
        end
    end

endmodule

// File: tb/tb_display_scanner.sv
// Directed bench for display_scanner at REFRESH_DIV=4, BLINK_HALF=10.
// Latency: n/a. Backpressure: n/a.
// Every cycle of each frame is compared against hand-derived anode/seg/dp values.
module tb_display_scanner;

    localparam logic [6:0] D0 = 7'b0111111;
    localparam logic [6:0] D1 = 7'b0000110;
    localparam logic [6:0] D2 = 7'b1011011;
    localparam logic [6:0] D3 = 7'b1001111;
    localparam logic [6:0] D4 = 7'b1100110;
    localparam logic [6:0] D5 = 7'b1101101;
    localparam logic [6:0] D7 = 7'b0000111;
    localparam logic [6:0] D8 = 7'b1111111;
    localparam logic [6:0] D9 = 7'b1101111;
    localparam logic [6:0] BL = 7'b0000000;

    logic clk = 1'b0;
    logic rst;

    display_scanner_if ifc ();

    display_scanner #(
        .REFRESH_DIV (4),
        .BLINK_HALF  (10),
        .SEG_ZERO    (D0),
        .SEG_BLANK   (BL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // mid-frame input change applied after step chg_at of run_frame
    int         chg_at = -1;
    logic [6:0] nxt_so;
    logic [6:0] nxt_mo;
    logic       nxt_mag;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // three cycles between reset release and the first tick: all dark
    task automatic lead_in();
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("lead_an[%0d]", i), {3'b000, ifc.an}, 7'b0001111);
            chk($sformatf("lead_seg[%0d]", i), ifc.seg, BL);
            chk($sformatf("lead_dp[%0d]", i), {6'd0, ifc.dp}, 7'd1);
        end
    endtask

    // Called just before a frame-wrap edge; checks len cycles of the frame.
    // Each slot: one dark cycle then three lit cycles, seg/dp held for 4.
    task automatic run_frame(input logic [6:0] e0, input logic [6:0] e1,
                             input logic [6:0] e2, input logic [6:0] e3,
                             input logic dp2, input int len);
        for (int i = 0; i < len; i++) begin
            int         slot;
            logic [3:0] oh;
            logic [3:0] exp_an;
            logic [6:0] exp_seg;
            logic       exp_dp;
            step();
            slot    = i / 4;
            oh      = 4'b0001 << slot;
            exp_an  = ((i % 4) == 0) ? 4'b1111 : ~oh;
            exp_seg = (slot == 0) ? e0 : (slot == 1) ? e1 : (slot == 2) ? e2 : e3;
            exp_dp  = (slot == 2) ? dp2 : 1'b1;
            chk($sformatf("an[%0d]", i), {3'b000, ifc.an}, {3'b000, exp_an});
            chk($sformatf("seg[%0d]", i), ifc.seg, exp_seg);
            chk($sformatf("dp[%0d]", i), {6'd0, ifc.dp}, {6'd0, exp_dp});
            if (i == chg_at) begin
                ifc.sec_ones_segs = nxt_so;
                ifc.min_ones_segs = nxt_mo;
                ifc.mag_on        = nxt_mag;
            end
        end
        chg_at = -1;
    endtask

    initial begin
        ifc.mag_on        = 1'b0;
        ifc.sec_ones_segs = D1;
        ifc.sec_tens_segs = D2;
        ifc.min_ones_segs = D3;
        ifc.min_tens_segs = D4;
        nxt_so  = BL;
        nxt_mo  = BL;
        nxt_mag = 1'b0;
        rst     = 1'b1;

        // reset state
        step();
        chk("rst_an", {3'b000, ifc.an}, 7'b0001111);
        chk("rst_seg", ifc.seg, BL);
        chk("rst_dp", {6'd0, ifc.dp}, 7'd1);
        step();
        rst = 1'b0;

        // basic scan of 1,2,3,4; steady colon with mag_on=0
        lead_in();
        run_frame(D1, D2, D3, D4, 1'b0, 16);
        run_frame(D1, D2, D3, D4, 1'b0, 16);

        // leading-zero blanking on 00:59, then 01:59
        ifc.min_tens_segs = D0;
        ifc.min_ones_segs = D0;
        ifc.sec_ones_segs = D5;
        ifc.sec_tens_segs = D9;
        run_frame(D5, D9, BL, BL, 1'b0, 16);
        ifc.min_ones_segs = D1;
        run_frame(D5, D9, D1, BL, 1'b0, 16);

        // change right after a wrap: invisible until the next frame
        chg_at  = 0;
        nxt_so  = D7;
        nxt_mo  = D8;
        nxt_mag = 1'b0;
        run_frame(D5, D9, D1, BL, 1'b0, 16);
        run_frame(D7, D9, D8, BL, 1'b0, 16);

        // mag_on rises on a wrap edge and stays 60 cycles; colon samples at
        // rise+8,+24,+40 (on) and +56 (off, after five toggles)
        ifc.mag_on = 1'b1;
        run_frame(D7, D9, D8, BL, 1'b0, 16);
        run_frame(D7, D9, D8, BL, 1'b0, 16);
        run_frame(D7, D9, D8, BL, 1'b0, 16);
        chg_at  = 11;
        nxt_so  = D7;
        nxt_mo  = D8;
        nxt_mag = 1'b0;
        run_frame(D7, D9, D8, BL, 1'b1, 16);
        run_frame(D7, D9, D8, BL, 1'b0, 16);

        // mag_on dropped while blink is off: colon must come back steady
        ifc.mag_on = 1'b1;
        chg_at  = 11;
        nxt_mag = 1'b0;
        run_frame(D7, D9, D8, BL, 1'b0, 16);
        run_frame(D7, D9, D8, BL, 1'b0, 16);

        // reset while slot 2 is lit with the colon on
        run_frame(D7, D9, D8, BL, 1'b0, 10);
        rst = 1'b1;
        step();
        chk("mid_rst_an", {3'b000, ifc.an}, 7'b0001111);
        chk("mid_rst_seg", ifc.seg, BL);
        chk("mid_rst_dp", {6'd0, ifc.dp}, 7'd1);
        rst = 1'b0;
        lead_in();
        run_frame(D7, D9, D8, BL, 1'b0, 16);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/display_scanner.md
Name: display_scanner

Overview:
- Downstream stage of the microwave controller.
- Consumes the four decoded 7-segment digit buses and mag_on, and time-multiplexes them onto one shared segment bus with active-low digit anodes.
- Adds leading-zero blanking on the minutes digits, an inter-digit ghosting gap, and a colon that blinks while the magnetron is on.

Parameters:
REFRESH_DIV, 50000, clk cycles per digit slot (minimum 4)
BLINK_HALF, 25000000, clk cycles per colon blink half-period while mag_on=1
SEG_ZERO, 7'b0111111, segment pattern the decoder emits for digit 0
SEG_BLANK, 7'b0000000, segment pattern meaning all segments dark

Ports:
clk  input  1  system clock, single clock domain
rst  input  1  synchronous reset, active-high
mag_on  input  1  magnetron active, from controller
sec_ones_segs  input  7  decoded seconds units
sec_tens_segs  input  7  decoded seconds tens
min_ones_segs  input  7  decoded minutes units
min_tens_segs  input  7  decoded minutes tens
seg  output  7  shared segment bus, registered
an  output  4  digit anodes, active-low one-hot, registered; bit0=sec_ones … bit3=min_tens
dp  output  1  colon/decimal point, active-low, registered

Behaviour:
- Interface decisions:
  - One clock, clk.
  - Reset rst is synchronous and active-high.
  - All state updates on posedge clk only.
- Reset values:
  - seg=SEG_BLANK, an=4'b1111, dp=1.
  - Prescaler=0, idx=3.
  - All snapshot regs=SEG_BLANK.
  - Blink counter=0, blink_on=1.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 and wraps to 0.
  - tick=1 for the single cycle where count==REFRESH_DIV-1.
- Digit index idx (2 bits):
  - Advances on tick; 3 wraps to 0.
  - Slot mapping: 0 sec_ones, 1 sec_tens, 2 min_ones, 3 min_tens.
- Frame snapshot:
  - On a tick where idx==3 (frame wraps), all four inputs are captured into snapshot regs.
  - All slots of a frame come from the same snapshot, so there is no tearing.
  - Input changes mid-frame are invisible until the next wrap.
  - The first frame after reset displays from snapshots taken at the first tick.
- Slot output pipeline, with T = tick cycle:
  - T+1: an=4'b1111 (ghost gap); seg and dp loaded for the new idx.
  - T+2: an drives the one-hot low bit for the new idx.
  - These values hold until the next tick.
- Leading-zero blanking, evaluated on snapshot values:
  - Slot 3 shows SEG_BLANK when min_tens==SEG_ZERO.
  - Slot 2 shows SEG_BLANK when min_tens==SEG_ZERO and min_ones==SEG_ZERO.
  - Slots 0 and 1 are never blanked (00 seconds stays visible).
  - Otherwise seg equals the snapshot pattern unmodified.
- Colon:
  - dp=0 only in slot 2, and only when colon_on; dp=1 in all other slots.
  - colon_on=1 when mag_on=0 (steady).
  - colon_on=blink_on when mag_on=1.
- Blink:
  - While mag_on=1, the counter counts 0..BLINK_HALF-1; at the terminal count it wraps and blink_on toggles.
  - While mag_on=0, the counter is held at 0 and blink_on=1.
  - So the colon is always on for the first full half-period after mag_on rises.
  - mag_on is sampled live, not snapshotted; the new colon state takes effect at the next slot-2 load.
- Boundary conditions:
  - Reset mid-slot returns all outputs to reset values in the next cycle; scanning resumes from slot 0.
  - Simultaneous tick and mag_on edge: the tick proceeds normally; the blink state updates in parallel.

Test Plan:
- REFRESH_DIV=4, BLINK_HALF=10; rst 2 cycles, then release. Inputs fixed at 1,2,3,4 patterns → an sequence 1110,1101,1011,0111 repeating every 16 cycles. Each preceded by one 1111 cycle. seg matches the slot's pattern at T+1.
- min_tens=min_ones=SEG_ZERO, sec=5,9 → slots 2 and 3 show seg=SEG_BLANK; slots 0 and 1 show the 5/9 patterns. Then min_ones=1 → slot 2 shows 1 from the next frame; slot 3 stays blank.
- Change sec_ones in the cycle after a wrap → the old value is shown for the rest of the frame; the new value appears only in the following frame.
- mag_on=0 → dp=0 in every slot-2 window. mag_on=1 for 60 cycles → colon on 10 cycles, off 10 cycles, alternating. mag_on drop → dp=0 at the next slot-2 window.
- Assert rst during slot 2 with colon on → next cycle an=1111, seg=SEG_BLANK, dp=1. After release, the first lit anode is 1110.
- REFRESH_DIV=4: assert tick spacing is exactly 4 cycles; an is never multi-hot; an=1111 for exactly 1 cycle per slot.
